// File: rtl/ptw_mem_responder.sv
// rtl/ptw_mem_responder.sv - page-table-walker read port bridged onto a single-outstanding backing memory
module ptw_mem_responder #(
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           data_req_i,
  input  logic                           data_we_i,
  input  logic [INDEX_WIDTH-1:0]         address_index_i,
  input  logic [TAG_WIDTH-1:0]           address_tag_i,
  input  logic                           tag_valid_i,
  input  logic                           kill_req_i,
  output logic                           data_gnt_o,
  output logic                           data_rvalid_o,
  output logic [DATA_WIDTH-1:0]          data_rdata_o,
  output logic                           mem_req_o,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  output logic                           protocol_err_o,
  output logic [31:0]                    resp_count_o
);

  localparam int AW = TAG_WIDTH + INDEX_WIDTH;
  // Walker fetches are doubleword-aligned, so the low byte-offset bits are dropped.
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(7);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TAG,
    MEM_REQ,
    MEM_WAIT,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;
  logic [31:0]             resp_count_q;
  logic                    capture_index;
  logic                    capture_tag;
  logic                    deliver;

  always_comb begin
    state_d        = state_q;
    data_gnt_o     = 1'b0;
    mem_req_o      = 1'b0;
    protocol_err_o = 1'b0;
    capture_index  = 1'b0;
    capture_tag    = 1'b0;
    deliver        = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (data_we_i) begin
            protocol_err_o = 1'b1;
          end else begin
            data_gnt_o    = 1'b1;
            capture_index = 1'b1;
            state_d       = WAIT_TAG;
          end
        end
      end
      WAIT_TAG: begin
        if (kill_req_i) begin
          state_d = IDLE;
        end else if (tag_valid_i) begin
          capture_tag = 1'b1;
          state_d     = MEM_REQ;
        end else begin
          protocol_err_o = 1'b1;
          state_d        = IDLE;
        end
      end
      MEM_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_d = kill_req_i ? DRAIN : MEM_WAIT;
        end else if (kill_req_i) begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        // A granted read is still in flight after a kill; wait it out in DRAIN.
        if (kill_req_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      index_q      <= '0;
      tag_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      resp_count_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= deliver;
      if (capture_index) begin
        index_q <= address_index_i;
      end
      if (capture_tag) begin
        tag_q <= address_tag_i;
      end
      if (deliver) begin
        rdata_q      <= mem_rdata_i;
        resp_count_q <= resp_count_q + 32'd1;
      end
    end
  end

  assign mem_addr_o    = {tag_q, index_q} & ADDR_MASK;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign resp_count_o  = resp_count_q;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb/tb_ptw_mem_responder.sv - directed and randomized bench for ptw_mem_responder
module tb_ptw_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [11:0] address_index_i;
  logic [43:0] address_tag_i;
  logic        tag_valid_i;
  logic        kill_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [63:0] data_rdata_o;
  logic        mem_req_o;
  logic [55:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        protocol_err_o;
  logic [31:0] resp_count_o;

  ptw_mem_responder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .data_req_i      (data_req_i),
    .data_we_i       (data_we_i),
    .address_index_i (address_index_i),
    .address_tag_i   (address_tag_i),
    .tag_valid_i     (tag_valid_i),
    .kill_req_i      (kill_req_i),
    .data_gnt_o      (data_gnt_o),
    .data_rvalid_o   (data_rvalid_o),
    .data_rdata_o    (data_rdata_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .protocol_err_o  (protocol_err_o),
    .resp_count_o    (resp_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_count = 0;
  logic [63:0] exp_rdata = 0;
  logic        exp_pulse = 0;

  localparam int K_NONE = 0, K_TAG = 1, K_REQ_NOGNT = 2, K_REQ_GNT = 3, K_WAIT = 4, K_WAIT_RV = 5;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One PTW read; the model only tracks how many reads completed and the last delivered word.
  task automatic run_txn(input int kind, input logic [11:0] idx, input logic [43:0] tg,
                         input logic [63:0] dat, input int gnt_dly, input int rv_dly);
    logic [63:0] exp_addr;
    logic        drain;
    exp_addr = ({8'h00, tg} * 64'd4096 + 64'(idx)) & ~64'h7;
    data_req_i      = 1'b1;
    data_we_i       = 1'b0;
    address_index_i = idx;
    kill_req_i      = 1'($urandom_range(0, 1));
    settle();
    check("grant", 64'(data_gnt_o), 64'd1);
    check("perr_idle", 64'(protocol_err_o), 64'd0);
    check("mem_req_idle", 64'(mem_req_o), 64'd0);
    check("rvalid_pulse", 64'(data_rvalid_o), 64'(exp_pulse));
    check("rdata", data_rdata_o, exp_rdata);
    check("resp_count", 64'(resp_count_o), 64'(exp_count));
    exp_pulse = 1'b0;
    tick();
    data_req_i      = 1'($urandom_range(0, 1));
    address_index_i = 12'($urandom());
    kill_req_i      = (kind == K_TAG);
    tag_valid_i     = 1'b1;
    address_tag_i   = tg;
    settle();
    check("gnt_wait_tag", 64'(data_gnt_o), 64'd0);
    check("rvalid_one_cycle", 64'(data_rvalid_o), 64'd0);
    check("perr_wait_tag", 64'(protocol_err_o), 64'd0);
    check("mem_req_wait_tag", 64'(mem_req_o), 64'd0);
    tick();
    tag_valid_i   = 1'b0;
    kill_req_i    = 1'b0;
    data_req_i    = 1'b0;
    address_tag_i = 44'({$urandom(), $urandom()});
    if (kind == K_TAG) return;
    for (int i = 0; i <= gnt_dly; i++) begin
      mem_gnt_i  = (i == gnt_dly) && (kind != K_REQ_NOGNT);
      kill_req_i = (i == gnt_dly) && (kind == K_REQ_NOGNT || kind == K_REQ_GNT);
      data_req_i = 1'($urandom_range(0, 1));
      settle();
      check("mem_req", 64'(mem_req_o), 64'd1);
      check("mem_addr", 64'(mem_addr_o), exp_addr);
      check("gnt_mem_req", 64'(data_gnt_o), 64'd0);
      tick();
    end
    mem_gnt_i  = 1'b0;
    kill_req_i = 1'b0;
    data_req_i = 1'b0;
    if (kind == K_REQ_NOGNT) return;
    drain = (kind == K_REQ_GNT);
    if (kind == K_WAIT) begin
      kill_req_i = 1'b1;
      settle();
      check("mem_req_wait", 64'(mem_req_o), 64'd0);
      tick();
      kill_req_i = 1'b0;
      drain      = 1'b1;
    end
    for (int i = 0; i < rv_dly; i++) begin
      data_req_i  = 1'b1;
      kill_req_i  = drain ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i = {$urandom(), $urandom()};
      settle();
      check("gnt_busy", 64'(data_gnt_o), 64'd0);
      check("mem_req_busy", 64'(mem_req_o), 64'd0);
      check("rvalid_busy", 64'(data_rvalid_o), 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = dat;
    data_req_i   = 1'b1;
    kill_req_i   = (kind == K_WAIT_RV) || (drain && 1'($urandom_range(0, 1)));
    settle();
    check("gnt_rvalid_cycle", 64'(data_gnt_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    kill_req_i   = 1'b0;
    data_req_i   = 1'b0;
    mem_rdata_i  = {$urandom(), $urandom()};
    if (kind == K_NONE) begin
      exp_pulse = 1'b1;
      exp_count = exp_count + 32'd1;
      exp_rdata = dat;
    end
  endtask

  task automatic run_random(input int n);
    int k;
    for (int t = 0; t < n; t++) begin
      k = int'($urandom_range(0, 9));
      run_txn(k < 5 ? K_NONE : k - 4, 12'($urandom()), 44'({$urandom(), $urandom()}),
              {$urandom(), $urandom()}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_i = 1'b1; data_req_i = 1'b0; data_we_i = 1'b0; address_index_i = '0; address_tag_i = '0;
    tag_valid_i = 1'b0; kill_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    tick();
    tick();
    settle();
    check("rst_gnt", 64'(data_gnt_o), 64'd0);
    check("rst_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_perr", 64'(protocol_err_o), 64'd0);
    check("rst_rdata", data_rdata_o, 64'd0);
    check("rst_count", 64'(resp_count_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    tick();
    rst_i = 1'b0;

    run_txn(K_NONE, 12'h010, 44'h80000, 64'hDEADBEEF, 0, 0);
    run_txn(K_NONE, 12'hABF, 44'h123456789, {$urandom(), $urandom()}, 5, 1);
    run_txn(K_TAG, 12'h020, 44'h55, 64'h1111, 0, 0);
    run_txn(K_WAIT, 12'h030, 44'h66, 64'h2222, 0, 2);

    data_req_i = 1'b1;
    data_we_i  = 1'b1;
    settle();
    check("we_no_gnt", 64'(data_gnt_o), 64'd0);
    check("we_perr", 64'(protocol_err_o), 64'd1);
    tick();
    data_we_i = 1'b0;
    settle();
    check("gnt_after_we", 64'(data_gnt_o), 64'd1);
    tick();
    data_req_i = 1'b0;
    settle();
    check("missing_tag_perr", 64'(protocol_err_o), 64'd1);
    tick();
    settle();
    check("perr_one_cycle", 64'(protocol_err_o), 64'd0);
    tick();

    run_random(40);
    run_txn(K_TAG, 12'h7, 44'h7, 64'h7, 0, 0);

    run_txn(K_WAIT_RV, 12'h040, 44'h77, 64'h3333, 0, 0);
    data_req_i = 1'b1; address_index_i = 12'h5A8;
    tick();
    data_req_i = 1'b0; tag_valid_i = 1'b1; address_tag_i = 44'hABC;
    tick();
    tag_valid_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check("rst_mid_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_mid_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mid_addr", 64'(mem_addr_o), 64'd0);
    check("rst_mid_count", 64'(resp_count_o), 64'd0);
    check("rst_mid_rdata", data_rdata_o, 64'd0);
    check("rst_mid_perr", 64'(protocol_err_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD0BAD0;
    tick();
    mem_rvalid_i = 1'b0;
    settle();
    check("stray_rvalid", 64'(data_rvalid_o), 64'd0);
    check("stray_count", 64'(resp_count_o), 64'd0);
    tick();
    exp_count = 0;
    exp_rdata = 0;
    exp_pulse = 1'b0;
    run_random(12);
    run_txn(K_TAG, 12'h8, 44'h8, 64'h8, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ptw_mem_responder.md
PTW_MEM_RESPONDER -- requirements
Module: ptw_mem_responder

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 12, cache index bits of request address.
REQ-002 SHALL have parameter TAG_WIDTH, default 44, tag bits of request address.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, read data width.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
 clk_i  in  1  clock, all state on rising edge
 rst_i  in  1  synchronous active-high reset
 data_req_i  in  1  PTW request, index phase
 data_we_i  in  1  write enable; reads only supported
 address_index_i  in  INDEX_WIDTH  index, valid with data_req_i
 address_tag_i  in  TAG_WIDTH  tag, valid with tag_valid_i
 tag_valid_i  in  1  tag phase strobe
 kill_req_i  in  1  abort outstanding request
 data_gnt_o  out  1  index phase accepted
 data_rvalid_o  out  1  read data valid, one-cycle pulse
 data_rdata_o  out  DATA_WIDTH  read data
 mem_req_o  out  1  backing memory request
 mem_addr_o  out  TAG_WIDTH+INDEX_WIDTH  byte address {tag,index}, bits[2:0] forced 0
 mem_gnt_i  in  1  backing memory accepted request
 mem_rvalid_i  in  1  backing memory read data valid
 mem_rdata_i  in  DATA_WIDTH  backing memory read data
 protocol_err_o  out  1  one-cycle pulse on protocol violation
 resp_count_o  out  32  count of delivered responses

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_TAG, MEM_REQ, MEM_WAIT, DRAIN.
REQ-006 IDLE: data_gnt_o SHALL equal data_req_i & ~data_we_i, combinationally; on grant capture address_index_i, next state WAIT_TAG.
REQ-007 IDLE with data_req_i & data_we_i: no grant, protocol_err_o SHALL pulse that cycle, stay IDLE.
REQ-008 data_gnt_o SHALL be 0 in every state except IDLE.
REQ-009 WAIT_TAG: kill_req_i -> IDLE, no response (kill wins over tag_valid_i same cycle); else tag_valid_i -> capture address_tag_i, MEM_REQ; else protocol_err_o pulses, IDLE.
REQ-010 MEM_REQ: mem_req_o SHALL be 1 with mem_addr_o stable; mem_gnt_i & ~kill_req_i -> MEM_WAIT; mem_gnt_i & kill_req_i -> DRAIN; kill_req_i without mem_gnt_i -> IDLE, mem_req_o deasserted next cycle.
REQ-011 mem_req_o SHALL be 0 outside MEM_REQ.
REQ-012 MEM_WAIT: mem_rvalid_i & ~kill_req_i -> register mem_rdata_i, assert data_rvalid_o next cycle for exactly one cycle, increment resp_count_o, IDLE.
REQ-013 MEM_WAIT: kill_req_i without mem_rvalid_i -> DRAIN; kill_req_i with mem_rvalid_i -> discard data, IDLE, no data_rvalid_o.
REQ-014 DRAIN: wait for mem_rvalid_i, discard data, no data_rvalid_o, then IDLE; kill_req_i ignored.
REQ-015 kill_req_i in IDLE SHALL have no effect; a same-cycle request is granted normally.
REQ-016 mem_rvalid_i outside MEM_WAIT/DRAIN SHALL be ignored.
REQ-017 Minimum latency: grant cycle 0, tag cycle 1, mem_req_o cycle 2, mem_gnt_i cycle 2, mem_rvalid_i cycle 3, data_rvalid_o cycle 4.
REQ-018 The cycle data_rvalid_o is high the FSM SHALL be IDLE and SHALL grant a new request.
REQ-019 data_rdata_o SHALL hold last delivered data until next delivery.
REQ-020 resp_count_o SHALL wrap from 0xFFFFFFFF to 0; killed/drained requests not counted.

Reset
REQ-021 rst_i high at a rising edge SHALL force IDLE; data_gnt_o (when data_req_i low), data_rvalid_o, mem_req_o, protocol_err_o SHALL be 0; data_rdata_o, captured index/tag, resp_count_o SHALL be 0.
REQ-022 Reset mid-operation SHALL abandon the request; a later mem_rvalid_i SHALL be ignored per REQ-016.

Verification
REQ-023 Read: req index 0x010, tag 0x80000, mem_gnt_i same cycle, rvalid 1 cycle later with 0xDEAD_BEEF -> mem_addr_o 0x80000010, data_rvalid_o cycle 4 with 0xDEADBEEF, resp_count_o=1.
REQ-024 Kill in WAIT_TAG with tag_valid_i=1 -> no mem_req_o, no data_rvalid_o, IDLE next cycle.
REQ-025 Kill in MEM_WAIT, mem_rvalid_i 3 cycles later -> data discarded, no data_rvalid_o, grant only after drain, resp_count_o unchanged.
REQ-026 data_req_i with data_we_i=1 -> data_gnt_o=0, protocol_err_o pulse; missing tag_valid_i after grant -> protocol_err_o pulse, IDLE.
REQ-027 mem_gnt_i held low 5 cycles -> mem_req_o and mem_addr_o stable all 5 cycles; back-to-back request granted in data_rvalid_o cycle.
REQ-028 rst_i asserted in MEM_WAIT -> all outputs 0 next cycle; stray mem_rvalid_i afterwards -> no data_rvalid_o.
